// File: rtl/i2c_xfer_seq.sv
// i2c_xfer_seq: register-level transaction sequencer driving a Wishbone
// I2C master core (PRER/CTR/TXR/RXR/CR/SR register map).
// Accepts single-register write or read requests addressed by a 7-bit device
// and an 8-bit register. Each request runs as a series of byte steps and
// finishes with one response pulse.
// Optional feature: define I2C_XFER_SEQ_TIMEOUT_EN to bound each status-poll
// phase to TIMEOUT_CYC cycles. On expiry a stop is issued and the request
// completes with err 11.
module i2c_xfer_seq #(
    parameter logic [15:0] PRESCALE    = 16'd99,
    parameter logic [19:0] TIMEOUT_CYC = 20'd100000
) (
    input  logic       wb_clk_i,
    input  logic       arst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rnw_i,
    input  logic [6:0] req_dev_i,
    input  logic [7:0] req_reg_i,
    input  logic [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic [1:0] rsp_err_o,
    output logic [2:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    output logic       wbm_we_o,
    output logic       wbm_stb_o,
    output logic       wbm_cyc_o,
    input  logic       wbm_ack_i
);

    typedef enum logic [3:0] {
        RST_INIT,
        IDLE,
        WR_TXR,
        WR_CR,
        POLL,
        CHK,
        STOP,
        POLL_BUSY,
        RD_RXR,
        RESP
    } state_t;

    localparam logic [2:0] ADR_TXR = 3'd3;  // TXR on write, RXR on read
    localparam logic [2:0] ADR_CR  = 3'd4;  // CR on write, SR on read
    localparam logic [7:0] CR_STO  = 8'h40;

    state_t     r_state;
    state_t     w_next;

    // Bus access registers
    logic       r_cyc;
    logic       r_we;
    logic [2:0] r_adr;
    logic [7:0] r_dat;

    // Captured request and step tracking
    logic [1:0] r_step;
    logic       r_rnw;
    logic [6:0] r_dev;
    logic [7:0] r_reg;
    logic [7:0] r_wdata;
    logic       r_sr_al;
    logic       r_sr_rxack;
    logic [1:0] r_err_pend;
    logic [1:0] r_rsp_err;
    logic [7:0] r_rsp_rdata;

    logic       w_ack;
    logic       w_issue;
    logic       w_we;
    logic [2:0] w_adr;
    logic [7:0] w_dat;
    logic [7:0] w_txr;
    logic [7:0] w_cr;
    logic [7:0] w_init_dat;
    logic       w_final_rd;
    logic       w_final_wr;
    logic       w_wd_hit;
    logic [1:0] w_fin_err;
    logic [7:0] w_fin_rdata;

    assign w_ack       = r_cyc & wbm_ack_i;
    assign w_final_rd  = r_rnw & (r_step == 2'd3);
    assign w_final_wr  = ~r_rnw & (r_step == 2'd2);

    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = r_we;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign req_ready_o = (r_state == IDLE);
    assign rsp_valid_o = (r_state == RESP);
    assign rsp_err_o   = r_rsp_err;
    assign rsp_rdata_o = r_rsp_rdata;

`ifdef I2C_XFER_SEQ_TIMEOUT_EN
    logic [19:0] r_wd;

    assign w_wd_hit = (r_wd >= TIMEOUT_CYC);

    // Watchdog: restarts on every entry into a poll phase, saturates at the limit
    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_wd <= '0;
        end else if (r_state != POLL && r_state != POLL_BUSY) begin
            r_wd <= '0;
        end else if (!w_wd_hit) begin
            r_wd <= r_wd + 20'd1;
        end
    end
`else
    logic w_unused;

    assign w_wd_hit = 1'b0;
    assign w_unused = ^TIMEOUT_CYC;
`endif

    // State register
    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= RST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: every bus state advances only on the core's ack
    always_comb begin
        w_next = r_state;
        case (r_state)
            RST_INIT:  if (w_ack && r_step == 2'd2) w_next = IDLE;
            IDLE:      if (req_valid_i) w_next = WR_TXR;
            WR_TXR:    if (w_ack) w_next = WR_CR;
            WR_CR:     if (w_ack) w_next = POLL;
            POLL: begin
                // A timeout is only taken between accesses so cyc/stb never drop mid-cycle
                if (!r_cyc && w_wd_hit)          w_next = STOP;
                else if (w_ack && !wbm_dat_i[1]) w_next = CHK;
            end
            CHK: begin
                if (r_sr_al)                          w_next = RESP;
                else if (r_sr_rxack && !w_final_rd)   w_next = STOP;
                else if (w_final_rd)                  w_next = RD_RXR;
                else if (w_final_wr)                  w_next = RESP;
                else if (r_rnw && r_step == 2'd2)     w_next = WR_CR;   // final read step has no TXR write
                else                                  w_next = WR_TXR;
            end
            STOP: begin
                // After a timeout the bus may be stuck, so skip waiting for BUSY to clear
                if (w_ack) w_next = (r_err_pend == 2'b11) ? RESP : POLL_BUSY;
            end
            POLL_BUSY: begin
                if (!r_cyc && w_wd_hit)          w_next = STOP;
                else if (w_ack && !wbm_dat_i[6]) w_next = RESP;
            end
            RD_RXR:    if (w_ack) w_next = RESP;
            RESP:      w_next = IDLE;
            default:   w_next = RST_INIT;
        endcase
    end

    // Output decode: which register access the current state wants to start
    always_comb begin
        w_issue = 1'b0;
        w_we    = 1'b0;
        w_adr   = '0;
        w_dat   = '0;

        case (r_step)
            2'd0:    w_txr = {r_dev, 1'b0};
            2'd1:    w_txr = r_reg;
            default: w_txr = r_rnw ? {r_dev, 1'b1} : r_wdata;
        endcase

        case (r_step)
            2'd0:    w_cr = 8'h90;
            2'd1:    w_cr = 8'h10;
            2'd2:    w_cr = r_rnw ? 8'h90 : 8'h50;
            default: w_cr = 8'h68;
        endcase

        case (r_step)
            2'd0:    w_init_dat = PRESCALE[7:0];
            2'd1:    w_init_dat = PRESCALE[15:8];
            default: w_init_dat = 8'h80;
        endcase

        case (r_state)
            RST_INIT: begin
                w_issue = ~r_cyc;
                w_we    = 1'b1;
                w_adr   = {1'b0, r_step};
                w_dat   = w_init_dat;
            end
            WR_TXR: begin
                w_issue = ~r_cyc;
                w_we    = 1'b1;
                w_adr   = ADR_TXR;
                w_dat   = w_txr;
            end
            WR_CR: begin
                w_issue = ~r_cyc;
                w_we    = 1'b1;
                w_adr   = ADR_CR;
                w_dat   = w_cr;
            end
            POLL, POLL_BUSY: begin
                w_issue = ~r_cyc & ~w_wd_hit;
                w_adr   = ADR_CR;
            end
            STOP: begin
                w_issue = ~r_cyc;
                w_we    = 1'b1;
                w_adr   = ADR_CR;
                w_dat   = CR_STO;
            end
            RD_RXR: begin
                w_issue = ~r_cyc;
                w_adr   = ADR_TXR;
            end
            default: ;
        endcase

        w_fin_err   = (r_state == CHK)    ? (r_sr_al ? 2'b10 : 2'b00) :
                      (r_state == RD_RXR) ? 2'b00 : r_err_pend;
        w_fin_rdata = (r_state == RD_RXR) ? wbm_dat_i : 8'h00;
    end

    // Bus engine, request capture, status capture and response registers
    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_step      <= '0;
            r_rnw       <= 1'b0;
            r_dev       <= '0;
            r_reg       <= '0;
            r_wdata     <= '0;
            r_sr_al     <= 1'b0;
            r_sr_rxack  <= 1'b0;
            r_err_pend  <= '0;
            r_rsp_err   <= '0;
            r_rsp_rdata <= '0;
        end else begin
            // Dropping cyc on ack and re-issuing only from an idle bus guarantees the gap cycle
            if (r_cyc) begin
                if (wbm_ack_i) r_cyc <= 1'b0;
            end else if (w_issue) begin
                r_cyc <= 1'b1;
                r_we  <= w_we;
                r_adr <= w_adr;
                r_dat <= w_dat;
            end

            if (r_state == RST_INIT && w_ack) begin
                r_step <= r_step + 2'd1;
            end

            if (r_state == IDLE && req_valid_i) begin
                r_rnw   <= req_rnw_i;
                r_dev   <= req_dev_i;
                r_reg   <= req_reg_i;
                r_wdata <= req_wdata_i;
                r_step  <= '0;
            end

            if (r_state == POLL && w_ack) begin
                r_sr_al    <= wbm_dat_i[5];
                r_sr_rxack <= wbm_dat_i[7];
            end

            if (r_state == CHK && (w_next == WR_TXR || w_next == WR_CR)) begin
                r_step <= r_step + 2'd1;
            end

            if (w_next == STOP && r_state != STOP) begin
                r_err_pend <= (r_state == CHK) ? 2'b01 : 2'b11;
            end

            if (w_next == RESP && r_state != RESP) begin
                r_rsp_err   <= w_fin_err;
                r_rsp_rdata <= w_fin_rdata;
            end
        end
    end

endmodule

// File: doc/i2c_xfer_seq.md
I2C_XFER_SEQ -- requirements
Module: i2c_xfer_seq

Interface
REQ-001 The module SHALL have parameter PRESCALE, default 16'd99, the value loaded into the I2C master core prescale register (PRER).
REQ-002 The module SHALL have parameter TIMEOUT_CYC, default 20'd100000, the wb_clk_i cycles allowed per status-poll phase.
REQ-003 The module SHALL have ports wb_clk_i input 1 (single clock) and arst_i input 1 (reset, asynchronous, active-high).
REQ-004 The module SHALL have request ports: req_valid_i input 1; req_ready_o output 1; req_rnw_i input 1 (1=read); req_dev_i input 7 (device address); req_reg_i input 8 (register address); req_wdata_i input 8.
REQ-005 The module SHALL have response ports: rsp_valid_o output 1 (one-cycle pulse); rsp_rdata_o output 8; rsp_err_o output 2 (00 ok, 01 NACK, 10 arbitration lost, 11 timeout).
REQ-006 The module SHALL have Wishbone master ports to the I2C master core: wbm_adr_o output 3; wbm_dat_o output 8; wbm_dat_i input 8; wbm_we_o output 1; wbm_stb_o output 1; wbm_cyc_o output 1; wbm_ack_i input 1.

Function
REQ-007 Each bus access SHALL assert cyc/stb with adr/dat/we stable until wbm_ack_i, then deassert cyc/stb for at least one cycle before the next access.
REQ-008 After reset the module SHALL run INIT: write PRER[7:0] to adr 0, PRER[15:8] to adr 1, then 0x80 to CTR (adr 2), and only then enter IDLE.
REQ-009 req_ready_o SHALL be 1 only in IDLE, and a request SHALL be accepted on the cycle when req_valid_i and req_ready_o are both 1; request fields SHALL be captured at acceptance.
REQ-010 A byte step SHALL write TXR (adr 3), write CR (adr 4), then read SR (adr 4) repeatedly until SR[1] (TIP) is 0.
REQ-011 Write transaction steps: {dev,0} with CR=0x90; reg with CR=0x10; wdata with CR=0x50 (STO|WR).
REQ-012 Read transaction steps: {dev,0} with CR=0x90; reg with CR=0x10; {dev,1} with CR=0x90 (repeated start); then CR=0x68 (STO|RD|NACK) with no TXR write, poll TIP; then read RXR (adr 3) into rsp_rdata_o.
REQ-013 After each step's final SR read, SR[5] (AL)=1 SHALL abort with err 10 and no stop; otherwise, on a step that is not the final read step, SR[7] (RxACK)=1 SHALL write CR=0x40, poll SR until SR[6] (BUSY)=0, then complete with err 01.
REQ-014 Completion SHALL pulse rsp_valid_o for exactly one cycle with rsp_err_o valid, then return to IDLE on the next cycle; rsp_rdata_o SHALL hold its last value until the next read completes and SHALL be 0x00 after a write or an error.
REQ-015 FSM states SHALL be RST_INIT, IDLE, WR_TXR, WR_CR, POLL, CHK, STOP, POLL_BUSY, RD_RXR, RESP.
REQ-016 req_valid_i asserted during INIT or a busy transfer SHALL be ignored (no capture, no ready).
REQ-017 Response latency SHALL depend only on the core's ack and TIP timing; no additional wait states SHALL be inserted.

Reset
REQ-018 arst_i SHALL asynchronously force state RST_INIT, req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0x00, rsp_err_o=00, wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_adr_o=0, wbm_dat_o=0x00.
REQ-019 Reset mid-transfer SHALL abandon the transfer with no response pulse and SHALL rerun INIT after release.

Configuration
REQ-020 With macro I2C_XFER_SEQ_TIMEOUT_EN defined, a 20-bit watchdog SHALL clear on entry to each POLL/POLL_BUSY phase, and reaching TIMEOUT_CYC SHALL write CR=0x40, complete with err 11 after one stop write, and return to IDLE.
REQ-021 Without I2C_XFER_SEQ_TIMEOUT_EN, there SHALL be no watchdog logic, polling SHALL be unbounded, and err 11 SHALL never be produced.

Verification
REQ-022 Reset release -> first three bus writes are adr0=0x63, adr1=0x00, adr2=0x80, then req_ready_o=1.
REQ-023 Write request dev=0x50 reg=0x12 data=0xA5 with an I2C slave model ACKing all bytes -> TXR writes 0xA0, 0x12, 0xA5; CR writes 0x90, 0x10, 0x50; one rsp_valid_o pulse with err 00.
REQ-024 Read request dev=0x50 reg=0x34 with the slave returning 0x5C -> TXR writes 0xA0, 0x34, 0xA1; CR writes 0x90, 0x10, 0x90, 0x68; rsp_rdata_o=0x5C, err 00.
REQ-025 Slave NACKs the address byte -> CR=0x40 is written, SR polled until BUSY=0, err 01, no further TXR writes.
REQ-026 Second master forces arbitration loss during the reg byte -> err 10, no CR=0x40 written; req_valid_i held high during the transfer is not accepted until IDLE.
REQ-027 With I2C_XFER_SEQ_TIMEOUT_EN and TIMEOUT_CYC=100, SCL held low by a slave -> err 11 about 100 cycles after the poll starts; arst_i pulsed mid-read -> no rsp_valid_o pulse and INIT is repeated.
